// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a four-digit common-anode
// seven-segment display. Captures the value, blank mask and decimal points
// once per frame, then scans digits 0..3. A dead-time at the start of each
// slot keeps all anodes off so the segment bus settles without ghosting.
//
// Interface timing: there is no valid/ready handshake. data_in, blank and
// dp_in are plain levels sampled on the single edge where the refresh
// counter is all-ones. frame_tick marks the first cycle of the frame in
// which the captured values take effect.
module seven_seg_scan #(
    parameter int COUNT_BITS  = 17,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  anode,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int SLOT_BITS = COUNT_BITS - 2;

    logic [COUNT_BITS-1:0] cnt;
    logic [1:0]            idx;
    logic [SLOT_BITS-1:0]  pos;
    logic                  cnt_max;
    logic                  past_dead;
    logic                  on;

    logic [15:0]           sh_data;
    logic [3:0]            sh_blank;
    logic [3:0]            sh_dp;

    logic [3:0]            nibble_d;
    logic [3:0]            anode_d;
    logic                  dp_n_d;

    assign idx     = cnt[COUNT_BITS-1:COUNT_BITS-2];
    assign pos     = cnt[SLOT_BITS-1:0];
    assign cnt_max = &cnt;

    // With no dead-time the comparison degenerates to "always true", so it
    // is resolved at elaboration instead of comparing against zero.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign past_dead = 1'b1;
        end else begin : g_dead
            localparam logic [SLOT_BITS-1:0] DEAD = SLOT_BITS'(DEAD_CYCLES);
            assign past_dead = (pos >= DEAD);
        end
    endgenerate

    assign on = past_dead & ~sh_blank[idx];

    // Free-running refresh counter; wraps every frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Frame shadows: load only at the last cycle of a frame so a digit
    // never tears mid-frame. Display stays dark until the first load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_data  <= 16'h0000;
            sh_blank <= 4'b1111;
            sh_dp    <= 4'b0000;
        end else if (cnt_max) begin
            sh_data  <= data_in;
            sh_blank <= blank;
            sh_dp    <= dp_in;
        end
    end

    // Next output values from the current counter and shadow state.
    always_comb begin
        nibble_d = sh_data[{idx, 2'b00} +: 4];
        anode_d  = 4'b1111;
        if (on) begin
            anode_d = ~(4'b0001 << idx);
        end
        dp_n_d   = ~(on & sh_dp[idx]);
    end

    // Registered outputs; the nibble is driven through dead-time too so the
    // decoder has settled before the anode turns on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_nibble <= 4'h0;
            anode        <= 4'b1111;
            dp_n         <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            digit_nibble <= nibble_d;
            anode        <= anode_d;
            dp_n         <= dp_n_d;
            frame_tick   <= cnt_max;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for seven_seg_scan with 4-cycle slots and
// a 16-cycle frame. One instance uses a single dead cycle, a second instance
// runs with no dead-time and a fixed value of 16'h1234.
module tb_seven_seg_scan;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  blank;
    logic [3:0]  dp_in;
    logic [3:0]  digit_nibble;
    logic [3:0]  anode;
    logic        dp_n;
    logic        frame_tick;

    logic [15:0] data_in0;
    logic [3:0]  blank0;
    logic [3:0]  dp_in0;
    logic [3:0]  nibble0;
    logic [3:0]  anode0;
    logic        dp_n0;
    logic        frame_tick0;

    seven_seg_scan #(.COUNT_BITS(4), .DEAD_CYCLES(1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .blank        (blank),
        .dp_in        (dp_in),
        .digit_nibble (digit_nibble),
        .anode        (anode),
        .dp_n         (dp_n),
        .frame_tick   (frame_tick)
    );

    seven_seg_scan #(.COUNT_BITS(4), .DEAD_CYCLES(0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in0),
        .blank        (blank0),
        .dp_in        (dp_in0),
        .digit_nibble (nibble0),
        .anode        (anode0),
        .dp_n         (dp_n0),
        .frame_tick   (frame_tick0)
    );

    // ---------------- hand-computed per-cycle tables (entry k at bits 4k) ----
    // Anode, dead cycle then three active cycles per digit.
    localparam logic [63:0] AN_SCAN  = 64'h777F_BBBF_DDDF_EEEF;
    // Digits 1 and 3 blanked.
    localparam logic [63:0] AN_BLANK = 64'hFFFF_BBBF_FFFF_EEEF;
    localparam logic [63:0] AN_DARK  = 64'hFFFF_FFFF_FFFF_FFFF;
    // No dead-time: one anode low in every cycle.
    localparam logic [63:0] AN_NODT  = 64'h7777_BBBB_DDDD_EEEE;
    localparam logic [63:0] NIB_1234 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] NIB_ABCD = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] NIB_ZERO = 64'h0000_0000_0000_0000;
    // dp_n per cycle (bit k): low only in digit 0 active cycles.
    localparam logic [15:0] DPN_OFF  = 16'hFFFF;
    localparam logic [15:0] DPN_D0   = 16'hFFF1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step nsteps cycles of a frame, checking both instances each cycle.
    // After the check at cycle hook_k the inputs of u_dut are changed.
    task automatic run_frame(input logic [63:0] an_tab, input logic [63:0] nib_tab,
                             input logic [15:0] dpn_tab, input bit scan0,
                             input int nsteps, input int hook_k,
                             input logic [15:0] hook_data, input logic [3:0] hook_blank,
                             input logic [3:0] hook_dp);
        logic [3:0] exp_an;
        logic [3:0] exp_an0;
        logic [3:0] exp_nib0;
        exp_q.delete();
        for (int k = 0; k < nsteps; k++) exp_q.push_back(an_tab[4*k +: 4]);
        for (int k = 0; k < nsteps; k++) begin
            tick();
            exp_an   = exp_q.pop_front();
            exp_an0  = scan0 ? AN_NODT[4*k +: 4]  : 4'hF;
            exp_nib0 = scan0 ? NIB_1234[4*k +: 4] : 4'h0;
            check($sformatf("anode c%0d", k),   {12'h0, anode},        {12'h0, exp_an});
            check($sformatf("nibble c%0d", k),  {12'h0, digit_nibble}, {12'h0, nib_tab[4*k +: 4]});
            check($sformatf("dp_n c%0d", k),    {15'h0, dp_n},         {15'h0, dpn_tab[k]});
            check($sformatf("tick c%0d", k),    {15'h0, frame_tick},   {15'h0, (k == 15)});
            check($sformatf("anode0 c%0d", k),  {12'h0, anode0},       {12'h0, exp_an0});
            check($sformatf("nibble0 c%0d", k), {12'h0, nibble0},      {12'h0, exp_nib0});
            check($sformatf("dp_n0 c%0d", k),   {15'h0, dp_n0},        16'h0001);
            check($sformatf("tick0 c%0d", k),   {15'h0, frame_tick0},  {15'h0, (k == 15)});
            if (k == hook_k) begin
                data_in = hook_data;
                blank   = hook_blank;
                dp_in   = hook_dp;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " anode"},  {12'h0, anode},        16'h000F);
        check({tag, " dp_n"},   {15'h0, dp_n},         16'h0001);
        check({tag, " nibble"}, {12'h0, digit_nibble}, 16'h0000);
        check({tag, " tick"},   {15'h0, frame_tick},   16'h0000);
        check({tag, " anode0"}, {12'h0, anode0},       16'h000F);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        data_in  = 16'h1234;
        blank    = 4'b0000;
        dp_in    = 4'b0000;
        data_in0 = 16'h1234;
        blank0   = 4'b0000;
        dp_in0   = 4'b0000;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // First frame: shadows still at reset values, display dark.
        run_frame(AN_DARK, NIB_ZERO, DPN_OFF, 1'b0, 16, -1, 16'h0, 4'h0, 4'h0);
        // 1234 frame; switch to ABCD mid-frame, which must not show yet.
        run_frame(AN_SCAN, NIB_1234, DPN_OFF, 1'b1, 16, 5, 16'hABCD, 4'b0000, 4'b0000);
        // ABCD frame; switch to blank 1010 / dp 0001 mid-frame.
        run_frame(AN_SCAN, NIB_ABCD, DPN_OFF, 1'b1, 16, 5, 16'hABCD, 4'b1010, 4'b0001);
        // Blanked frames, repeated to confirm the pattern is periodic.
        run_frame(AN_BLANK, NIB_ABCD, DPN_D0, 1'b1, 16, -1, 16'h0, 4'h0, 4'h0);
        run_frame(AN_BLANK, NIB_ABCD, DPN_D0, 1'b1, 16, -1, 16'h0, 4'h0, 4'h0);
        // Stop inside digit 2's active cycles.
        run_frame(AN_BLANK, NIB_ABCD, DPN_D0, 1'b1, 11, -1, 16'h0, 4'h0, 4'h0);

        // Asynchronous reset: outputs must clear before the next clock edge.
        #1 reset = 1'b1;
        #1 check_reset_state("midreset");
        @(negedge clk);
        data_in = 16'h1234;
        blank   = 4'b0000;
        dp_in   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        run_frame(AN_DARK, NIB_ZERO, DPN_OFF, 1'b0, 16, -1, 16'h0, 4'h0, 4'h0);
        run_frame(AN_SCAN, NIB_1234, DPN_OFF, 1'b1, 16, -1, 16'h0, 4'h0, 4'h0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scanner for a four-digit common-anode seven-segment display. It captures a 16-bit hex value, a per-digit blank mask and per-digit decimal points once per refresh frame. It then presents one nibble at a time on `digit_nibble`, which feeds the `Din` input of the combinational hex-to-segment decoder. It also drives the matching active-low anode and decimal-point pins, and inserts a dead-time at each digit change to prevent ghosting.

## Interface
- `COUNT_BITS`, default 17: refresh counter width. Each digit slot lasts 2^(COUNT_BITS-2) cycles; a frame lasts 2^COUNT_BITS cycles. Legal range is 4 or more.
- `DEAD_CYCLES`, default 16: cycles at the start of each slot during which all anodes are off. Must be less than 2^(COUNT_BITS-2); 0 disables dead-time.
- `clk`  in  1  system clock; the block uses this single clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  16  value to display. Nibble k is digit k; digit 0 is rightmost, `data_in[3:0]`.
- `blank`  in  4  per-digit blank. Bit k = 1 keeps anode k off for the whole frame.
- `dp_in`  in  4  per-digit decimal point. Bit k = 1 lights the DP while digit k is active.
- `digit_nibble`  out  4  nibble for the active digit; connects to the decoder `Din`.
- `anode`  out  4  active-low anode enables. At most one bit is low at any time.
- `dp_n`  out  1  active-low decimal point.
- `frame_tick`  out  1  one-cycle pulse. It is high in the first cycle of each frame in which newly captured values take effect.

## Operation
- Refresh counter `cnt` (COUNT_BITS wide):
  - Reset value is 0.
  - Increments by 1 every cycle and wraps from all-ones to 0.
- Counter fields:
  - Digit index `idx` = `cnt[COUNT_BITS-1:COUNT_BITS-2]`.
  - Slot position `pos` = `cnt[COUNT_BITS-3:0]`.
- Shadow registers `sh_data`, `sh_blank` and `sh_dp`:
  - Load `data_in`, `blank` and `dp_in` on the clock edge where `cnt` is all-ones. No other edge loads them.
  - Changes to the inputs mid-frame have no visible effect until the next frame, so there is no digit tearing.
  - Reset values: `sh_data` = 0, `sh_blank` = 4'b1111 (display dark until the first load), `sh_dp` = 0.
- Output register, updated every edge from the current `cnt` and shadow values:
  - `digit_nibble` <= `sh_data[4*idx +: 4]`. It is presented during dead-time as well, so the decoder output settles before the anode turns on.
  - Define `on` = (`pos` >= DEAD_CYCLES) and not `sh_blank[idx]`.
  - `anode` <= `on` ? ~(4'b0001 << `idx`) : 4'b1111.
  - `dp_n` <= ~(`on` and `sh_dp[idx]`).
  - `frame_tick` <= (`cnt` == all-ones).
- Scan order is digit 0, 1, 2, 3, then repeat.
- Reset asserted at any time, including mid-frame:
  - All registers clear immediately, without waiting for a clock edge.
  - The scan restarts from digit 0 after reset deasserts.
- Output reset values: `anode` = 4'b1111, `dp_n` = 1, `digit_nibble` = 4'h0, `frame_tick` = 0.

## Timing
- Outputs are registered and lag `cnt` by one cycle. Let cycle 0 be the first rising edge after `reset` deasserts, with `cnt` = 0 at that edge.
- Outputs for `cnt` = n are visible in the cycle following edge n.
- Shadow load happens at edge 2^COUNT_BITS - 1.
- `frame_tick` is high for exactly one cycle: the cycle after that edge. In that same cycle `cnt` = 0.
- The first output driven from the new shadow values appears one cycle after `frame_tick`.
- Within each slot, the anode is off for DEAD_CYCLES cycles, then low for 2^(COUNT_BITS-2) - DEAD_CYCLES cycles.
- Throughput is fixed: one digit per slot with no stalls. Inputs need no handshake; they are sampled once per frame.

## Test plan
All scenarios use COUNT_BITS=4 and DEAD_CYCLES=1 (4-cycle slots, 16-cycle frame) unless noted otherwise.

- **Reset and first frame:** hold `reset` high with `data_in`=16'h1234 and `blank`=0. Required: `anode`=4'b1111, `dp_n`=1 and `digit_nibble`=0. After release, `anode` stays 4'b1111 for 16 cycles, and `frame_tick` pulses once in cycle 16.
- **Normal scan:** with `data_in`=16'h1234 loaded, each slot shows 1 dead cycle then 3 active cycles.
  - Digit 0: `digit_nibble`=4, `anode`=4'b1110.
  - Digit 1: `digit_nibble`=3, `anode`=4'b1101.
  - Digit 2: `digit_nibble`=2, `anode`=4'b1011.
  - Digit 3: `digit_nibble`=1, `anode`=4'b0111.
  - The pattern repeats every 16 cycles.
- **Frame coherence:** change `data_in` to 16'hABCD at cycle 5 of a frame. The rest of that frame still shows 4,3,2,1; the next frame shows D,C,B,A. `frame_tick` is high only in the first cycle of each frame.
- **Blank and DP:** set `blank`=4'b1010 and `dp_in`=4'b0001. Anodes 1 and 3 never go low. `dp_n` is low only in cycles where `anode`=4'b1110, and it is 1 during dead cycles.
- **Mid-frame reset:** assert `reset` during digit 2's active cycles. `anode` goes to 4'b1111 and `dp_n` to 1 before the next clock edge. After release, the display behaves as in the reset-and-first-frame scenario.
- **No dead-time (DEAD_CYCLES=0, `blank`=0):** exactly one `anode` bit is low in every cycle after the first frame, and digits change on 4-cycle boundaries.
